num_ascii_tx: RTL and testbench

Serialises a binary value onto the codebase's byte-wide UART transmit handshake (`tx_data`/`tx_start`/`tx_busy`) as decimal ASCII text. It performs the inverse of the digit-accumulating parsers used by the mode FSMs. It sits between any mode FSM that needs to print a number (settings echo, matrix element display) and the shared UART transmitter. It handles binary-to-BCD conversion, leading-zero suppression, an optional sign and a selectable trailing separator.

---
 rtl/num_ascii_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_num_ascii_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/num_ascii_tx.sv
// num_ascii_tx
// Prints a binary value as decimal ASCII text on the byte-wide UART transmit
// handshake. The value goes through double-dabble conversion. Leading zero
// digits are suppressed, an optional leading '-' is added, and one of three
// trailing separators follows the digits.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   value_in     value to print, sampled when value_valid && value_ready
//   value_valid  print request
//   sep_sel      separator, sampled with value_in:
//                  00 none, 01/11 space, 10 CR LF
//   value_ready  high only while idle
//   tx_data      byte presented to the UART
//   tx_start     one-cycle launch pulse for tx_data
//   tx_busy      UART busy
//   done         one-cycle pulse after the last byte has been launched
//
// Build option:
//   NUM_ASCII_TX_SIGNED_EN  treat value_in as two's complement and print a
//                           leading '-' for negative values.
module num_ascii_tx #(
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned DIGITS      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic                   value_valid,
    input  logic [1:0]             sep_sel,
    output logic                   value_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   done
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_SIGN,
        S_DIGITS,
        S_SEP,
        S_DONE
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;

    logic [VALUE_WIDTH-1:0]         r_mag;
    logic [BCD_W-1:0]               r_bcd;
    logic [CNT_W-1:0]               r_cnt;
    logic [IDX_W-1:0]               r_idx;
    logic                           r_seen;
    logic                           r_neg;
    logic [1:0]                     r_sep;
    logic                           r_sep_idx;
    logic [7:0]                     r_tx_data;
    logic                           r_tx_start;

    logic                           w_accept;
    logic                           w_can_emit;
    logic [3:0]                     w_nib;
    logic                           w_is_last;
    logic                           w_skip;
    logic [BCD_W-1:0]               w_bcd_adj;
    logic [BCD_W+VALUE_WIDTH-1:0]   w_dd;
    logic [VALUE_WIDTH-1:0]         w_mag_in;
    logic                           w_neg_in;
    logic                           w_emit;
    logic [7:0]                     w_byte;

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;

    assign w_accept   = value_valid && (r_state == S_IDLE);
    // The registered tx_start blocks the edge right after a launch, so two
    // launches can never be on adjacent edges.
    assign w_can_emit = !tx_busy && !r_tx_start;

`ifdef NUM_ASCII_TX_SIGNED_EN
    assign w_neg_in = value_in[VALUE_WIDTH-1];
    assign w_mag_in = w_neg_in ? (~value_in + VALUE_WIDTH'(1)) : value_in;
`else
    assign w_neg_in = 1'b0;
    assign w_mag_in = value_in;
`endif

    // Double-dabble step: add 3 to each BCD nibble >= 5, then shift
    // {bcd, magnitude} left by one bit.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) begin
                w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
            end
        end
        w_dd = {w_bcd_adj, r_mag} << 1;
    end

    always_comb begin
        w_nib = 4'd0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_idx == IDX_W'(d)) begin
                w_nib = r_bcd[d*4 +: 4];
            end
        end
    end

    assign w_is_last = (r_idx == '0);
    assign w_skip    = (w_nib == 4'd0) && !r_seen && !w_is_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_CONVERT;
            S_CONVERT: if (r_cnt == CNT_W'(1)) w_state_nxt = S_SIGN;
            S_SIGN:    if (!r_neg || w_can_emit) w_state_nxt = S_DIGITS;
            S_DIGITS:  if (!w_skip && w_can_emit && w_is_last) w_state_nxt = S_SEP;
            S_SEP: begin
                if (r_sep == 2'b00) begin
                    w_state_nxt = S_DONE;
                end else if (w_can_emit && (r_sep != 2'b10 || r_sep_idx)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_emit      = 1'b0;
        w_byte      = 8'h00;
        value_ready = (r_state == S_IDLE);
        done        = (r_state == S_DONE);
        unique case (r_state)
            S_SIGN: begin
                if (r_neg && w_can_emit) begin
                    w_emit = 1'b1;
                    w_byte = 8'h2D;
                end
            end
            S_DIGITS: begin
                if (!w_skip && w_can_emit) begin
                    w_emit = 1'b1;
                    w_byte = {4'h3, w_nib};
                end
            end
            S_SEP: begin
                if (r_sep != 2'b00 && w_can_emit) begin
                    w_emit = 1'b1;
                    if (r_sep == 2'b10) begin
                        w_byte = r_sep_idx ? 8'h0A : 8'h0D;
                    end else begin
                        w_byte = 8'h20;
                    end
                end
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_seen     <= 1'b0;
            r_neg      <= 1'b0;
            r_sep      <= 2'b00;
            r_sep_idx  <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= w_emit;
            if (w_emit) begin
                r_tx_data <= w_byte;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mag     <= w_mag_in;
                        r_neg     <= w_neg_in;
                        r_sep     <= sep_sel;
                        r_bcd     <= '0;
                        r_cnt     <= CNT_W'(VALUE_WIDTH);
                        r_idx     <= IDX_W'(DIGITS - 1);
                        r_seen    <= 1'b0;
                        r_sep_idx <= 1'b0;
                    end
                end
                S_CONVERT: begin
                    r_bcd <= w_dd[BCD_W+VALUE_WIDTH-1 -: BCD_W];
                    r_mag <= w_dd[VALUE_WIDTH-1:0];
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_DIGITS: begin
                    if (w_skip) begin
                        r_idx <= r_idx - IDX_W'(1);
                    end else if (w_can_emit) begin
                        r_seen <= 1'b1;
                        if (!w_is_last) begin
                            r_idx <= r_idx - IDX_W'(1);
                        end
                    end
                end
                S_SEP: begin
                    if (w_emit) begin
                        r_sep_idx <= 1'b1;
                    end
                end
                default: begin
                    r_sep_idx <= r_sep_idx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_num_ascii_tx.sv
module tb_num_ascii_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] value_in;
    logic       value_valid;
    logic [1:0] sep_sel;
    logic       value_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    // UART model and monitor state
    logic       busy_mode = 1'b0;
    int         bcnt = 0;
    logic [7:0] q[$];
    int         done_cnt = 0;
    int         dbl_err = 0;
    int         launch_err = 0;
    int         stab_err = 0;
    logic       prev_start = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] last_data = 8'h00;
    int         d0;

    num_ascii_tx #(.VALUE_WIDTH(8), .DIGITS(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .sep_sel     (sep_sel),
        .value_ready (value_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // The UART stays busy for 10 cycles after each launch when busy_mode is set.
    assign tx_busy = busy_mode && (bcnt != 0);

    always @(posedge clk) begin
        if (tx_start) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    always @(negedge clk) begin
        if (tx_start) begin
            q.push_back(tx_data);
            last_data <= tx_data;
            if (prev_start) dbl_err <= dbl_err + 1;
            if (prev_busy) launch_err <= launch_err + 1;
        end else if (tx_busy && tx_data !== last_data) begin
            stab_err <= stab_err + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        prev_start <= tx_start;
        prev_busy  <= tx_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v, input logic [1:0] s);
        q.delete();
        d0 = done_cnt;
        @(negedge clk);
        value_in    = v;
        sep_sel     = s;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        value_in    = 8'($urandom);
        sep_sel     = 2'($urandom);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt != d0) break;
        end
        repeat (4) @(negedge clk);
        check({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_seq(input string tag, input string e);
        check({tag, " byte count"}, 32'(q.size()), 32'(e.len()));
        for (int i = 0; i < e.len(); i++) begin
            if (i < q.size()) check($sformatf("%s byte%0d", tag, i), 32'(q[i]), 32'(e[i]));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        value_in    = 8'h00;
        value_valid = 1'b0;
        sep_sel     = 2'b00;
        repeat (3) @(negedge clk);
        check("reset value_ready", 32'(value_ready), 32'd1);
        check("reset tx_start", 32'(tx_start), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'h00);
        check("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(8'd0, 2'b01);
        wait_done("zero");
        check_seq("zero", "0 ");

        send(8'd255, 2'b10);
        wait_done("v255");
        check_seq("v255", "255\015\012");

        send(8'd7, 2'b00);
        wait_done("v7");
        check_seq("v7", "7");

`ifdef NUM_ASCII_TX_SIGNED_EN
        send(8'h80, 2'b01);
        wait_done("m128");
        check_seq("m128", "-128 ");
        send(8'hFF, 2'b00);
        wait_done("m1");
        check_seq("m1", "-1");
        send(8'h7F, 2'b00);
        wait_done("p127");
        check_seq("p127", "127");
`else
        send(8'h80, 2'b11);
        wait_done("u128");
        check_seq("u128", "128 ");
        send(8'hFF, 2'b00);
        wait_done("uFF");
        check_seq("uFF", "255");
`endif
        check("no back-to-back tx_start", 32'(dbl_err), 32'd0);

        // Slow UART
        busy_mode = 1'b1;
        send(8'd42, 2'b00);
        wait_done("v42 busy");
        check_seq("v42 busy", "42");
        check("launch while busy", 32'(launch_err), 32'd0);
        check("tx_data stable while busy", 32'(stab_err), 32'd0);
        busy_mode = 1'b0;

        // Request during an in-progress print is ignored
        send(8'd100, 2'b00);
        repeat (3) @(negedge clk);
        check("ready low while busy", 32'(value_ready), 32'd0);
        value_in    = 8'd99;
        sep_sel     = 2'b01;
        value_valid = 1'b1;
        @(negedge clk);
        check("ready low during pulse", 32'(value_ready), 32'd0);
        value_valid = 1'b0;
        wait_done("v100");
        check_seq("v100", "100");
        check("ready after v100", 32'(value_ready), 32'd1);

        // Reset abort after first digit
        send(8'd123, 2'b01);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (q.size() >= 1) break;
        end
        check("abort first byte seen", 32'(q.size()), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort tx_start", 32'(tx_start), 32'd0);
        check("abort tx_data", 32'(tx_data), 32'h00);
        check("abort value_ready", 32'(value_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort no done", 32'(done_cnt - d0), 32'd0);
        check("abort no more bytes", 32'(q.size()), 32'd1);

        send(8'd5, 2'b00);
        wait_done("v5");
        check_seq("v5", "5");
        check("final no back-to-back", 32'(dbl_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
